// File: rtl/axicb_decerr_slv.sv
// Default responder behind the crossbar: completes every unmapped AXI4 request
// with DECERR, returning the request ID in acceptance order on each channel.

module axicb_decerr_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];
endmodule

module axicb_decerr_slv #(
    parameter int                    AXI_ID_W    = 8,
    parameter int                    AXI_DATA_W  = 32,
    parameter int                    OSTDREQ_NUM = 4,
    parameter logic [AXI_DATA_W-1:0] RDATA_VAL   = '0
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [AXI_ID_W-1:0]   awid,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic                  wlast,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [AXI_ID_W-1:0]   bid,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [AXI_ID_W-1:0]   arid,
    input  logic [7:0]            arlen,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [AXI_ID_W-1:0]   rid,
    output logic [1:0]            rresp,
    output logic [AXI_DATA_W-1:0] rdata,
    output logic                  rlast
);
    localparam int CW = $clog2(OSTDREQ_NUM) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(OSTDREQ_NUM);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    logic [CW-1:0]         aw_count, b_count, ar_count;
    logic [AXI_ID_W-1:0]   aw_head;
    logic [AXI_ID_W+7:0]   ar_head;
    logic                  aw_push, aw_pop, b_push, b_pop, ar_push, ar_pop;
    logic                  state;
    logic [7:0]            cnt;

    // Readies are forced low while reset is asserted, not just after it.
    assign awready = aresetn && (aw_count != FULL_CNT);
    assign arready = aresetn && (ar_count != FULL_CNT);
    assign wready  = aresetn && (aw_count != '0) && (b_count != FULL_CNT);

    assign aw_push = awvalid && awready;
    assign aw_pop  = wvalid && wready && wlast;
    assign b_push  = aw_pop;
    assign b_pop   = bvalid && bready;
    assign ar_push = arvalid && arready;
    assign ar_pop  = rvalid && rready && rlast;

    axicb_decerr_fifo #(.W(AXI_ID_W), .DEPTH(OSTDREQ_NUM)) u_aw_fifo (
        .clk(aclk), .rst_n(aresetn), .push(aw_push), .din(awid),
        .pop(aw_pop), .dout(aw_head), .count(aw_count)
    );

    axicb_decerr_fifo #(.W(AXI_ID_W), .DEPTH(OSTDREQ_NUM)) u_b_fifo (
        .clk(aclk), .rst_n(aresetn), .push(b_push), .din(aw_head),
        .pop(b_pop), .dout(bid), .count(b_count)
    );

    axicb_decerr_fifo #(.W(AXI_ID_W + 8), .DEPTH(OSTDREQ_NUM)) u_ar_fifo (
        .clk(aclk), .rst_n(aresetn), .push(ar_push), .din({arid, arlen}),
        .pop(ar_pop), .dout(ar_head), .count(ar_count)
    );

    assign bvalid = (b_count != '0);
    assign bresp  = 2'b11;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ar_count != '0) begin
                        state <= ST_BURST;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (rvalid && rready) begin
                        if (rlast) begin
                            // Another request already queued (or arriving now): no bubble.
                            if ((ar_count > ONE_CNT) || ar_push) cnt <= '0;
                            else state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign rvalid = (state == ST_BURST);
    assign rid    = ar_head[AXI_ID_W+7:8];
    assign rlast  = (cnt == ar_head[7:0]);
    assign rresp  = 2'b11;
    assign rdata  = RDATA_VAL;
endmodule

// File: doc/axicb_decerr_slv.md
Name: axicb_decerr_slv

Overview:
- Default responder slave behind the crossbar switch. It terminates every AXI4 request that decodes to no mapped slave.
- It returns spec-compliant completions with DECERR: one B per write burst, and ARLEN+1 R beats per read burst.
- Its completions carry the request ID. Master-side completion ordering logic therefore sees them exactly like completions from a real slave.
- It is the completion source for misrouted transactions.

Parameters:
- AXI_ID_W, 8, ID width in bits
- AXI_DATA_W, 32, R data width in bits
- OSTDREQ_NUM, 4, outstanding requests per direction; the AW, B and AR FIFOs are each this deep (power of 2, ≥2)
- RDATA_VAL, 0, constant driven on rdata for every DECERR beat (AXI_DATA_W bits)

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- awid  in  AXI_ID_W  write address ID
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- wlast  in  1  last write beat
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- bid  out  AXI_ID_W  write response ID
- bresp  out  2  write response, always 2'b11
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- arid  in  AXI_ID_W  read address ID
- arlen  in  8  read burst length minus one
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rid  out  AXI_ID_W  read data ID
- rresp  out  2  read response, always 2'b11
- rdata  out  AXI_DATA_W  read data, always RDATA_VAL
- rlast  out  1  last read beat

Behaviour:

Reset:
- While aresetn=0, all valids and readies are 0, and FIFOs and counters are cleared.
- Reset mid-burst discards all in-flight state. No partial beat is emitted after release.
- First cycle after release: awready=1, arready=1, wready=0, bvalid=0, rvalid=0.

Write path:
- AW handshake (awvalid&awready) pushes awid into the AW FIFO.
- awready = !aw_full. It is not relieved by a same-cycle pop.
- wready = !aw_empty && !b_full. W beats are accepted only after their AW; W-before-AW stalls.
- Every W handshake is discarded.
- A W handshake with wlast=1 pops the AW FIFO head and pushes that ID into the B FIFO in the same cycle.
- bvalid = !b_empty, and bid = B FIFO head.
- Pop on bvalid&bready. Once bvalid is asserted it holds until the handshake, with bid stable.
- Minimum latency: wlast handshake at cycle T gives bvalid at T+1.
- AW, W and B may all handshake in the same cycle. Push and pop on a non-full, non-empty FIFO in one cycle leave the count unchanged.

Read path:
- AR handshake pushes {arid, arlen} into the AR FIFO.
- arready = !ar_full, with the same rule as awready.
- Read FSM has two states, IDLE and BURST, plus an 8-bit beat counter cnt.
- IDLE: if !ar_empty, go to BURST and set cnt=0. rvalid=0 in IDLE.
- BURST:
  - Drives rvalid=1, rid=head.arid, rlast=(cnt==head.arlen), rresp=2'b11, rdata=RDATA_VAL.
  - On rvalid&rready&!rlast: cnt increments.
  - On rvalid&rready&rlast: pop the AR FIFO. If the FIFO is non-empty after the pop (including a same-cycle push), stay in BURST with cnt=0, giving back-to-back bursts with no bubble. Otherwise go to IDLE.
- All R outputs are stable while rvalid=1 and rready=0.
- Latency: AR handshake at T gives the first rvalid at T+2 (IDLE→BURST transition). Beats then stream one per cycle while rready=1.
- arlen=255 gives 256 beats. cnt never wraps, because the FIFO pops on the last beat.

Ordering:
- Completions within each channel return in request-acceptance order, regardless of ID.
- Read and write paths are fully independent.

Test Plan:
- Reset release: after aresetn 0→1, awready=1, arready=1, wready=0, bvalid=0, rvalid=0. Assert aresetn=0 mid read burst (after 3 of 8 beats) → rvalid drops immediately; no beats follow after release.
- Single write: AW id=0x05, then 4 W beats with wlast on beat 4, bready=1 → one B with bid=0x05, bresp=2'b11, one cycle after the wlast handshake. wready=0 before the AW handshake.
- Read burst: AR id=0x3A, arlen=7, rready=1 → 8 consecutive beats with rid=0x3A, rresp=2'b11, rdata=RDATA_VAL, rlast only on beat 8. First rvalid 2 cycles after the AR handshake.
- Back-pressure and full: OSTDREQ_NUM=4, five ARs with rready=0 → arready low after the 4th AR. Toggle rready randomly → every beat is held stable, beat counts are exact, and the IDs return in order.
- Back-to-back reads: ARs id=1 arlen=0, then id=2 arlen=255 → the id=1 single beat (rlast=1) is followed the next cycle by the first id=2 beat; 256 id=2 beats in total.
- Concurrent traffic: interleave 20 random AW/W/AR with random bready/rready stalls → B count=20 writes, R beats=sum of (arlen+1), IDs in acceptance order, no handshake lost.
